// File: rtl/serial_shift_pkg.sv
// Shared types and constants for the serial shift initiator.
package serial_shift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } state_e;

  localparam logic CE_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b1;
  localparam int unsigned HALF_DIV_MIN = 3;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period timer: phase_end_o marks the last system clock of each HALF_DIV-long phase.
import serial_shift_pkg::*;

module sclk_tick_gen #(
  parameter int HALF_DIV = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic phase_end_o
);

  // Divisors below the minimum are clamped so the phase timing stays well defined.
  localparam int HD = (HALF_DIV < int'(HALF_DIV_MIN)) ? int'(HALF_DIV_MIN) : HALF_DIV;
  localparam int CW = $clog2(HD);
  localparam logic [CW-1:0] LAST = CW'(HD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign phase_end_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_shift_master.sv
// Serial shift initiator: drives ce/sclk/sdo, shifts tx LSB first and captures sdi into rx.
import serial_shift_pkg::*;

module serial_shift_master #(
  parameter int WIDTH    = 7,
  parameter int HALF_DIV = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             ce_o,
  output logic             sclk_o,
  output logic             sdo_o,
  input  logic             sdi_i
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sync1_q, sync2_q;
  logic             ce_q, ce_d, sclk_q, sclk_d, sdo_q, sdo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             phase_end;

  sclk_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .restart_i  (state_q == ST_IDLE),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          tx_d    = tx_data_i;
          rx_d    = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: if (phase_end) state_d = ST_LOW;
      ST_LOW:   if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          rx_d            = rx_q >> 1;
          rx_d[WIDTH-1]   = sync2_q;
          tx_d            = tx_q >> 1;
          bit_d           = bit_q + BW'(1);
          state_d         = (bit_q == LAST_BIT) ? ST_HOLD : ST_LOW;
        end
      end
      ST_HOLD: begin
        if (phase_end) begin
          state_d   = ST_IDLE;
          rx_data_d = rx_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the next state so every output comes straight from a flop.
    ce_d   = (state_d == ST_IDLE) ? CE_IDLE : ~CE_IDLE;
    sclk_d = (state_d == ST_LOW) ? ~SCLK_IDLE : SCLK_IDLE;
    busy_d = (state_d != ST_IDLE);
    sdo_d  = 1'b0;
    if (state_d == ST_LOW)       sdo_d = tx_d[0];
    else if (state_d == ST_HIGH) sdo_d = sdo_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      ce_q      <= CE_IDLE;
      sclk_q    <= SCLK_IDLE;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      sync1_q   <= sdi_i;
      sync2_q   <= sync1_q;
      ce_q      <= ce_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign ce_o      = ce_q;
  assign sclk_o    = sclk_q;
  assign sdo_o     = sdo_q;

endmodule

// File: tb/tb_serial_shift_master.sv
// Bench for serial_shift_master: main instance (7,5) plus sweep instances (1,3) and (16,3).
module tb_serial_shift_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, start1, start2;
  logic [6:0]  tx0;
  logic [0:0]  tx1;
  logic [15:0] tx2;
  logic [6:0]  rx0;
  logic [0:0]  rx1;
  logic [15:0] rx2;
  logic        busy [3];
  logic        done [3];
  logic        ce   [3];
  logic        sclk [3];
  logic        sdo  [3];
  logic        sdi0, sdi_drv;
  int          mode;
  logic [6:0]  resp_word;

  // mode 0: loopback, 1: responder presents resp_word bit i at sclk fall i,
  // 2: responder raises sdi after the first sclk rise and drops it at the second fall
  assign sdi0 = (mode == 0) ? sdo[0] : sdi_drv;

  serial_shift_master #(.WIDTH(7), .HALF_DIV(5)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .tx_data_i(tx0),
    .busy_o(busy[0]), .done_o(done[0]), .rx_data_o(rx0), .ce_o(ce[0]),
    .sclk_o(sclk[0]), .sdo_o(sdo[0]), .sdi_i(sdi0));

  serial_shift_master #(.WIDTH(1), .HALF_DIV(3)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .tx_data_i(tx1),
    .busy_o(busy[1]), .done_o(done[1]), .rx_data_o(rx1), .ce_o(ce[1]),
    .sclk_o(sclk[1]), .sdo_o(sdo[1]), .sdi_i(sdo[1]));

  serial_shift_master #(.WIDTH(16), .HALF_DIV(3)) dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start2), .tx_data_i(tx2),
    .busy_o(busy[2]), .done_o(done[2]), .rx_data_o(rx2), .ce_o(ce[2]),
    .sclk_o(sclk[2]), .sdo_o(sdo[2]), .sdi_i(sdo[2]));

  function automatic int hk(input int k);
    return (k == 0) ? 5 : 3;
  endfunction

  // Bus observer: phase lengths, sclk falls, busy length, sdo bits seen at each fall.
  int         run_len [3], bad_run [3], tail [3], falls [3], last_falls [3];
  int         busy_run [3], last_busy [3], done_cnt [3];
  int         rises0;
  logic       prev_sclk [3], prev_ce [3], prev_busy [3];
  logic [6:0] cur_sdo, last_sdo, sh_tmp;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k]) done_cnt[k]++;
      if (busy[k]) busy_run[k]++;
      else if (prev_busy[k] === 1'b1) begin
        last_busy[k] = busy_run[k];
        busy_run[k]  = 0;
      end
      if (ce[k]) begin
        if (prev_ce[k] === 1'b0) begin
          tail[k]       = run_len[k];
          last_falls[k] = falls[k];
          if (k == 0) last_sdo = cur_sdo;
        end
        run_len[k] = 0;
        falls[k]   = 0;
        if (k == 0) begin
          cur_sdo = '0;
          rises0  = 0;
          sdi_drv = 1'b0;
        end
      end else if (sclk[k] !== prev_sclk[k]) begin
        if (run_len[k] != hk(k)) bad_run[k]++;
        run_len[k] = 1;
        if (!sclk[k]) begin
          if (k == 0 && falls[k] < 7) begin
            cur_sdo = cur_sdo | (7'(sdo[0]) << falls[k]);
            sh_tmp  = resp_word >> falls[k];
            if (mode == 1) sdi_drv = sh_tmp[0];
            if (mode == 2 && falls[k] == 1) sdi_drv = 1'b0;
          end
          falls[k]++;
        end else if (k == 0) begin
          if (mode == 2 && rises0 == 0) sdi_drv = 1'b1;
          rises0++;
        end
      end else begin
        run_len[k]++;
      end
      prev_sclk[k] = sclk[k];
      prev_ce[k]   = ce[k];
      prev_busy[k] = busy[k];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input int limit);
    int n;
    n = 0;
    while (done[k] !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done[k]), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ce"},   32'(ce[0]),   32'd1);
    check({tag, "_sclk"}, 32'(sclk[0]), 32'd1);
    check({tag, "_sdo"},  32'(sdo[0]),  32'd0);
    check({tag, "_busy"}, 32'(busy[0]), 32'd0);
    check({tag, "_done"}, 32'(done[0]), 32'd0);
    check({tag, "_rx"},   32'(rx0),     32'd0);
  endtask

  task automatic start_main(input logic [6:0] tx);
    tx0    = tx;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tx0    = 7'($urandom);
  endtask

  task automatic check_txn(input string tag, input logic [6:0] exp_tx, input logic [6:0] exp_rx);
    check({tag, "_sdo_bits"}, 32'(last_sdo),  32'(exp_tx));
    check({tag, "_rx"},       32'(rx0),       32'(exp_rx));
    check({tag, "_busy_len"}, last_busy[0],   32'd80);
    check({tag, "_falls"},    last_falls[0],  32'd7);
  endtask

  logic [6:0] a, b;
  int         d0, d1, d2;

  initial begin
    mode = 0; resp_word = '0; reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tx0 = '0; tx1 = '0; tx2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle("reset");
    check("reset_rx16", 32'(rx2), 32'd0);

    // Loopback 7'h69: bits 1,0,0,1,0,1,1 on successive falls.
    d0 = done_cnt[0];
    start_main(7'h69);
    check("accept_ce", 32'(ce[0]), 32'd0);
    check("accept_busy", 32'(busy[0]), 32'd1);
    wait_done(0, 200);
    check_txn("loop69", 7'h69, 7'h69);
    check("loop69_ce_with_done", 32'(ce[0]), 32'd1);
    check("loop69_tail", tail[0], 32'd10);
    tick();
    check("loop69_done_once", done_cnt[0] - d0, 32'd1);

    // Random words from an independent responder.
    for (int i = 0; i < 6; i++) begin
      a = 7'($urandom);
      b = 7'($urandom);
      mode = 1; resp_word = b;
      start_main(a);
      wait_done(0, 200);
      check_txn("rand", a, b);
      tick();
    end

    // Responder raises sdi after the first sclk rise only.
    mode = 2;
    a = 7'($urandom);
    start_main(a);
    wait_done(0, 200);
    check_txn("first_bit", a, 7'h01);
    tick();
    mode = 0;

    // Reset mid-SETUP.
    start_main(7'($urandom));
    repeat (2) tick();
    check("pre_rst_setup", {30'd0, ce[0], sclk[0]}, 32'd1);
    reset = 1'b1;
    tick();
    check_idle("rst_setup");
    repeat (2) tick();
    reset = 1'b0;
    d0 = done_cnt[0];
    repeat (100) tick();
    check("rst_setup_no_done", done_cnt[0] - d0, 32'd0);

    // Reset mid-LOW, after a transfer left rx_data nonzero.
    a = 7'($urandom) | 7'h01;
    start_main(a);
    wait_done(0, 200);
    check("pre_rst_rx", 32'(rx0), 32'(a));
    tick();
    start_main(7'($urandom));
    repeat (7) tick();
    check("pre_rst_low", {30'd0, ce[0], sclk[0]}, 32'd0);
    reset = 1'b1;
    tick();
    check_idle("rst_low");
    repeat (2) tick();
    reset = 1'b0;
    d0 = done_cnt[0];
    repeat (100) tick();
    check("rst_low_no_done", done_cnt[0] - d0, 32'd0);

    // Starts while busy are ignored; tx_data changes mid-transfer have no effect.
    a = 7'($urandom);
    d0 = done_cnt[0];
    start_main(a);
    for (int n = 1; n < 200 && done[0] !== 1'b1; n++) begin
      start0 = (n == 10 || n == 30 || n == 60);
      tx0    = 7'($urandom);
      tick();
    end
    start0 = 1'b0;
    check("ignore_done_seen", 32'(done[0]), 32'd1);
    check_txn("ignore", a, a);
    repeat (20) tick();
    check("ignore_one_done", done_cnt[0] - d0, 32'd1);

    // Back-to-back: start in the done cycle.
    a = 7'($urandom);
    b = 7'($urandom);
    start_main(a);
    wait_done(0, 200);
    check_txn("b2b_first", a, a);
    check("b2b_ce_high", 32'(ce[0]), 32'd1);
    start_main(b);
    check("b2b_ce_low_next", 32'(ce[0]), 32'd0);
    check("b2b_busy_next", 32'(busy[0]), 32'd1);
    wait_done(0, 200);
    check_txn("b2b_second", b, b);
    tick();

    // Sweep: WIDTH=1 and WIDTH=16 with HALF_DIV=3.
    tx1 = 1'($urandom);
    tx2 = 16'($urandom);
    d1 = done_cnt[1];
    d2 = done_cnt[2];
    start1 = 1'b1; start2 = 1'b1;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    wait_done(2, 400);
    tick();
    check("w1_rx",       32'(rx1),      32'(tx1));
    check("w1_falls",    last_falls[1], 32'd1);
    check("w1_busy_len", last_busy[1],  32'd12);
    check("w1_tail",     tail[1],       32'd6);
    check("w1_one_done", done_cnt[1] - d1, 32'd1);
    check("w16_rx",      32'(rx2),      32'(tx2));
    check("w16_falls",   last_falls[2], 32'd16);
    check("w16_busy_len", last_busy[2], 32'd102);
    check("w16_tail",    tail[2],       32'd6);
    check("w16_one_done", done_cnt[2] - d2, 32'd1);
    check("phase_len_main", bad_run[0], 32'd0);
    check("phase_len_w1",   bad_run[1], 32'd0);
    check("phase_len_w16",  bad_run[2], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
